lab4_sweep_checker: RTL
=======================

// Module: lab4_sweep_checker
// PURPOSE
//  Exhaustive stimulus/response stage for the 7-input Lab4 boolean logic block.
//  Drives all 128 input vectors a..g in ascending order and samples the block's single output.
//  Compares each sample against a golden truth table and reports pass/fail,
//  error count and first failing vector; sits directly around the combinational function under test.
// PARAMETERS
//  GOLDEN   128'h0  truth table; bit k = expected out for vector k (stim = k)
//  LATENCY  0       cycles from stim to valid dut_out (0..3; 0 = purely combinational DUT)
// PORTS
//  clk             in   1  single clock, rising edge
//  reset           in   1  synchronous, active-high
//  start           in   1  begin a sweep; sampled only in IDLE or DONE
//  stim            out  7  vector to DUT: stim[6]=a ... stim[0]=g
//  dut_out         in   1  DUT output for vector issued LATENCY cycles earlier
//  busy            out  1  high in SWEEP and DRAIN
//  done            out  1  one-cycle pulse on entry to DONE
//  pass            out  1  err_count==0; valid in DONE, held until next start
//  err_count       out  8  mismatches this sweep (0..128)
//  first_fail_idx  out  7  vector index of first mismatch
//  first_fail_vld  out  1  at least one mismatch recorded
//  misr            out  16 response signature (only with LAB4_MISR_EN)
// BEHAVIOUR
//  - Reset: state IDLE; stim, busy, done, pass, err_count, first_fail_idx, first_fail_vld, misr all 0.
//  - States: IDLE -start-> SWEEP -(stim==127 issued)-> DRAIN (LATENCY cycles; skipped if 0) -> DONE -start-> SWEEP.
//  - start in IDLE/DONE: clear err_count, first_fail_*, misr, pass; next cycle stim=0, busy=1.
//  - start while busy: ignored, no effect on sweep.
//  - SWEEP: stim increments by 1 each cycle, 0..127, exactly 128 issue cycles, no wrap; stim holds 127 through DRAIN.
//  - Compare pipe: LATENCY-deep shift of {valid, idx}; LATENCY=0 compares dut_out against the current stim in the same cycle.
//  - Compare cycle: mismatch = dut_out ^ GOLDEN[idx]; err_count += mismatch (8 bit, cannot overflow).
//  - first_fail_idx/first_fail_vld: written on the first mismatch only; later mismatches leave them unchanged.
//  - Completion: exactly 128 compares, then DONE; done pulses 1 cycle at start+128+LATENCY+1.
//  - DONE outputs: pass=(err_count==0); results held; stim returns to 0.
//  - IDLE: stim=0, no compares.
//  - reset mid-sweep: abort immediately to reset values, no done pulse; pipe valids cleared.
// CONFIGURATION
//  LAB4_MISR_EN defined:
//   - 16-bit MISR, poly 0x1021, seed 0.
//   - Each compare cycle: misr <= {misr[14:0],1'b0} ^ (misr[15]?16'h1021:0) ^ {15'b0,dut_out}.
//   - Cleared on start/reset; held in DONE.
//  LAB4_MISR_EN undefined: misr port and register absent; all other behaviour identical.
// STRUCTURE
//  - Shared package lab4_pkg: N_IN=7, N_VEC=128, MISR_POLY=16'h1021, state enum {IDLE,SWEEP,DRAIN,DONE}.
//  - Sub-module lab4_misr (clk, reset, clr, en, din, sig), instantiated only under LAB4_MISR_EN.
//  - FSM, stim counter, compare pipe and error logic live in this module.
// TESTING
//  1. GOLDEN = truth table of the minimized function, DUT = that function, LATENCY=0, start pulse
//     -> stim 0..127, done at cycle 129, pass=1, err_count=0, first_fail_vld=0.
//  2. Same, DUT output inverted only at stim==5
//     -> err_count=1, first_fail_idx=5, first_fail_vld=1, pass=0.
//  3. DUT output inverted at stim 9 and 100
//     -> err_count=2, first_fail_idx=9.
//  4. LATENCY=2, DUT registered twice
//     -> busy for 130 cycles, done at cycle 131, pass=1.
//  5. reset asserted when stim==60
//     -> next cycle all outputs 0, state IDLE; following start restarts at stim=0 and passes.
//  6. start held high throughout the sweep, then pulsed again in DONE
//     -> first sweep unaffected; second sweep clears results and passes; with LAB4_MISR_EN, misr equals the bench model after each sweep.

Source files
------------

// File: rtl/lab4_pkg.sv
// ============================================================================
// Module      : lab4_pkg
// Description : Shared constants and state encoding for the Lab4 sweep checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lab4_pkg;

    localparam int N_IN  = 7;
    localparam int N_VEC = 128;

    localparam logic [15:0] MISR_POLY = 16'h1021;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lab4_misr.sv
// ============================================================================
// Module      : lab4_misr
// Description : 16-bit serial-input response signature register (poly 0x1021).
//               Instantiated by lab4_sweep_checker only when LAB4_MISR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lab4_misr
    import lab4_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] sig
);

    logic [15:0] r_sig;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_sig <= '0;
        end else if (en) begin
            r_sig <= {r_sig[14:0], 1'b0} ^ (r_sig[15] ? MISR_POLY : 16'h0000) ^ {15'b0, din};
        end
    end

    assign sig = r_sig;

endmodule

`default_nettype wire

// File: rtl/lab4_sweep_checker.sv
// ============================================================================
// Module      : lab4_sweep_checker
// Description : Drives all 128 input vectors into the Lab4 logic block and
//               checks each response against a golden truth table.
//               Optional response signature enabled by LAB4_MISR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lab4_sweep_checker
    import lab4_pkg::*;
#(
    parameter logic [N_VEC-1:0] GOLDEN  = '0,
    parameter int               LATENCY = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [7:0]      err_count,
    output logic [N_IN-1:0] first_fail_idx,
    output logic            first_fail_vld
`ifdef LAB4_MISR_EN
    ,
    output logic [15:0]     misr
`endif
);

    localparam logic [N_IN-1:0] c_last_vec   = N_IN'(N_VEC - 1);
    localparam logic [1:0]      c_drain_last = 2'((LATENCY == 0) ? 0 : LATENCY - 1);

    state_t          r_state;
    state_t          w_next;
    logic [N_IN-1:0] r_stim;
    logic [1:0]      r_drain;
    logic            r_done;
    logic [7:0]      r_err;
    logic [N_IN-1:0] r_ffi;
    logic            r_ffv;

    logic            w_start_ok;
    logic            w_cmp_vld;
    logic [N_IN-1:0] w_cmp_idx;
    logic            w_mis;

    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start) w_next = SWEEP;
            SWEEP: if (r_stim == c_last_vec) w_next = (LATENCY == 0) ? DONE : DRAIN;
            DRAIN: if (r_drain == c_drain_last) w_next = DONE;
            DONE:  if (start) w_next = SWEEP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_stim  <= '0;
            r_drain <= 2'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == DONE) && (r_state != DONE);
            r_drain <= (r_state == DRAIN) ? r_drain + 2'd1 : 2'd0;
            // stim advances only while sweeping and parks at 127 through the drain
            if ((r_state == SWEEP) && (w_next == SWEEP)) begin
                r_stim <= r_stim + N_IN'(1);
            end else if (w_next == DONE) begin
                r_stim <= '0;
            end
        end
    end

    // Compare pipe: realigns each issued index with the response it produced
    generate
        if (LATENCY == 0) begin : g_pipe_comb
            assign w_cmp_vld = (r_state == SWEEP);
            assign w_cmp_idx = r_stim;
        end else begin : g_pipe_reg
            logic [LATENCY-1:0] r_pv;
            logic [N_IN-1:0]    r_pi [LATENCY];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pv <= '0;
                end else begin
                    r_pv[0] <= (r_state == SWEEP);
                    for (int i = 1; i < LATENCY; i++) begin
                        r_pv[i] <= r_pv[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_pi[0] <= r_stim;
                for (int i = 1; i < LATENCY; i++) begin
                    r_pi[i] <= r_pi[i-1];
                end
            end

            assign w_cmp_vld = r_pv[LATENCY-1];
            assign w_cmp_idx = r_pi[LATENCY-1];
        end
    endgenerate

    assign w_mis = w_cmp_vld && (dut_out ^ GOLDEN[w_cmp_idx]);

    always_ff @(posedge clk) begin
        if (reset || w_start_ok) begin
            r_err <= 8'd0;
            r_ffi <= '0;
            r_ffv <= 1'b0;
        end else if (w_mis) begin
            r_err <= r_err + 8'd1;
            if (!r_ffv) begin
                r_ffv <= 1'b1;
                r_ffi <= w_cmp_idx;
            end
        end
    end

`ifdef LAB4_MISR_EN
    lab4_misr u_misr (
        .clk   (clk),
        .reset (reset),
        .clr   (w_start_ok),
        .en    (w_cmp_vld),
        .din   (dut_out),
        .sig   (misr)
    );
`endif

    assign stim           = r_stim;
    assign busy           = (r_state == SWEEP) || (r_state == DRAIN);
    assign done           = r_done;
    assign pass           = (r_state == DONE) && (r_err == 8'd0);
    assign err_count      = r_err;
    assign first_fail_idx = r_ffi;
    assign first_fail_vld = r_ffv;

endmodule

`default_nettype wire
